// File: rtl/mod_n_updown_counter_pkg.sv
// Shared encodings for the modulo-N counter family: count direction,
// terminal behaviour and the two-state run/done machine.
package mod_n_updown_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;

    typedef enum logic {
        ST_COUNTING = 1'b0,
        ST_DONE     = 1'b1
    } state_e;

endpackage

// File: rtl/mod_n_updown_counter.sv
// Parametrised modulo-N up/down counter with synchronous load, wrap or
// one-shot terminal behaviour, a registered terminal-count pulse and a
// combinational carry for chaining into the next stage's En.
module mod_n_updown_counter
    import mod_n_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MODULUS     = 2 ** WIDTH,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clock50,
    input  logic             Mr,
    input  logic             En,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up_dn,
    input  logic             one_shot,
    output logic [WIDTH-1:0] Qout,
    output logic             Tc,
    output logic             done,
    output logic             carry_out
);

    // Highest legal count, truncated to the counter width so that
    // MODULUS = 2**WIDTH becomes the all-ones natural wrap point.
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VALUE);

    if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH) || RESET_VALUE >= MODULUS) begin : g_bad_params
        $error("mod_n_updown_counter: illegal MODULUS/RESET_VALUE for WIDTH");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] terminal;
    logic             at_term;
    logic [WIDTH-1:0] load_clamped;

    // Terminal depends on the direction presented this cycle.
    always_comb begin
        terminal     = (up_dn == DIR_UP) ? MAX_VAL : '0;
        at_term      = (count_q == terminal);
        load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end

    // State, count and terminal pulse registers with synchronous reset.
    always_ff @(posedge clock50) begin
        if (Mr) begin
            state_q <= ST_COUNTING;
            count_q <= RESET_CNT;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    // Next state / next count: load beats counting; DONE ignores En.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (load_en) begin
            count_d = load_clamped;
            state_d = ST_COUNTING;
        end else if (En && state_q == ST_COUNTING) begin
            if (!at_term) begin
                // Away from the terminal the step never leaves 0..MODULUS-1.
                count_d = (up_dn == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
            end else if (one_shot == MODE_ONESHOT) begin
                state_d = ST_DONE;
                tc_d    = 1'b1;
            end else begin
                count_d = (up_dn == DIR_UP) ? '0 : MAX_VAL;
                tc_d    = 1'b1;
            end
        end
    end

    // Outputs: registered count/pulse, done from state, combinational carry.
    always_comb begin
        Qout      = count_q;
        Tc        = tc_q;
        done      = (state_q == ST_DONE);
        carry_out = En && (state_q == ST_COUNTING) && at_term;
    end

endmodule
